mux_arbiter: RTL and testbench

Two-requester arbiter that shares a single 3-bit output path between sources `in1` and `in2`. It owns the select of the 2:1 output mux: it registers one grant at a time, bounds how long a holder keeps the path while the other source waits, and alternates fairly on ties. It sits in front of any consumer that reads one shared 3-bit bus fed by two producers.

---
 rtl/mux_arbiter.sv | 83 ++++++++
 tb/tb_mux_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester arbiter owning the select of a shared output mux
module mux_arbiter #(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             gnt1,
  output logic             gnt2,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, G1 = 2'd1, G2 = 2'd2} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic       last2, last2_nxt;   // 1: requester 2 was granted most recently

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      last2    <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last2    <= last2_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req1 && req2)  state_nxt = last2 ? G1 : G2;
        else if (req1)     state_nxt = G1;
        else if (req2)     state_nxt = G2;
      end
      G1: begin
        if (!req1)         state_nxt = req2 ? G2 : IDLE;
        else if (req2 && hold_cnt >= HOLD_LIMIT) state_nxt = G2;
      end
      G2: begin
        if (!req2)         state_nxt = req1 ? G1 : IDLE;
        else if (req1 && hold_cnt >= HOLD_LIMIT) state_nxt = G1;
      end
      default:             state_nxt = IDLE;
    endcase
  end

  // Counter restarts at 1 on any grant entry, saturates while the grant persists.
  always_comb begin
    hold_cnt_nxt = 4'd0;
    last2_nxt    = last2;
    if (state_nxt != IDLE) begin
      if (state_nxt != state) begin
        hold_cnt_nxt = 4'd1;
        last2_nxt    = (state_nxt == G2);
      end else if (hold_cnt < HOLD_LIMIT) begin
        hold_cnt_nxt = hold_cnt + 4'd1;
      end else begin
        hold_cnt_nxt = hold_cnt;
      end
    end
  end

  always_comb begin
    gnt1      = (state == G1);
    gnt2      = (state == G2);
    out_valid = gnt1 | gnt2;
    out1      = '0;
    if (gnt1)      out1 = in1;
    else if (gnt2) out1 = in2;
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req1, req2;
  logic [2:0] in1, in2;
  logic       gnt1, gnt2, out_valid;
  logic [2:0] out1;

  int n_vec = 0;
  int n_err = 0;

  mux_arbiter #(.WIDTH(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2),
    .in1(in1), .in2(in2), .gnt1(gnt1), .gnt2(gnt2),
    .out1(out1), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit g1, input bit g2, input int data);
    check_eq({tag, ".gnt1"}, int'(gnt1), int'(g1));
    check_eq({tag, ".gnt2"}, int'(gnt2), int'(g2));
    check_eq({tag, ".valid"}, int'(out_valid), int'(g1 | g2));
    check_eq({tag, ".out1"}, int'(out1), data);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req1 = 1'b1; req2 = 1'b1; in1 = 3'b101; in2 = 3'b010;
    #1;
    expect_out("rst_hold", 0, 0, 0);
    step(); step();
    expect_out("rst_edge", 0, 0, 0);
    rst_n = 1'b1;

    // Continuous contention: G1 edges 1-4, G2 5-8, G1 9-12.
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k <= 4 || k >= 9) expect_out($sformatf("cont%0d", k), 1, 0, 5);
      else                  expect_out($sformatf("cont%0d", k), 0, 1, 2);
    end
    req1 = 1'b0; req2 = 1'b0;
    step();
    expect_out("cont_release", 0, 0, 0);

    // Single requester held well past MAX_HOLD.
    req2 = 1'b1; in2 = 3'b110;
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out($sformatf("single%0d", k), 0, 1, 6);
    end
    check_eq("single_sat", int'(dut.hold_cnt), 4);
    req2 = 1'b0;
    step();
    expect_out("single_drop", 0, 0, 0);

    // Tie after G2 -> requester 1 wins; then early release hands over with no bubble.
    req1 = 1'b1; req2 = 1'b1; in1 = 3'b011; in2 = 3'b100;
    step();
    expect_out("tie_after_g2", 1, 0, 3);
    step();
    check_eq("early_hold2", int'(dut.hold_cnt), 2);
    req1 = 1'b0;
    step();
    expect_out("early_handover", 0, 1, 4);
    check_eq("early_hold1", int'(dut.hold_cnt), 1);
    req2 = 1'b0;
    step();
    expect_out("early_idle", 0, 0, 0);

    // Grant G1 alone, release, then tie -> requester 2 wins.
    req1 = 1'b1;
    step();
    expect_out("solo_g1", 1, 0, 3);
    req1 = 1'b0;
    step();
    expect_out("solo_g1_idle", 0, 0, 0);
    req1 = 1'b1; req2 = 1'b1;
    step();
    expect_out("tie_after_g1", 0, 1, 4);

    // Asynchronous reset between edges while in G2.
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0);
    #2 rst_n = 1'b1;
    step();
    expect_out("restart_tie", 1, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
